issue_scoreboard_staller: RTL and testbench

ISSUE_SCOREBOARD_STALLER -- requirements
Module: issue_scoreboard_staller

---
 rtl/issue_scoreboard_staller.sv | 95 +++++++++
 tb/tb_issue_scoreboard_staller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_staller.sv
// In-order issue staller for a multi-slot bundle: per-register load countdowns
// block consumers, and a done mask lets a bundle drain across several cycles.
module issue_scoreboard_staller #(
  parameter int ISSUE_W  = 2,
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [ISSUE_W-1:0]              bundle_valid,
  input  logic [ISSUE_W*(REG_AW+1)-1:0]   src1,
  input  logic [ISSUE_W*(REG_AW+1)-1:0]   src2,
  input  logic [ISSUE_W*REG_AW-1:0]       dest,
  input  logic [ISSUE_W-1:0]              dest_we,
  input  logic [ISSUE_W-1:0]              is_load,
  output logic [ISSUE_W-1:0]              issue_valid,
  output logic                            enable,
  output logic [(1<<REG_AW)-1:0]          busy_map,
  output logic [15:0]                     stall_count
);
  localparam int NREGS = 1 << REG_AW;
  localparam int SW = REG_AW + 1;
  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  logic [2:0]         cnt     [NREGS];
  logic [2:0]         cnt_nxt [NREGS];
  logic [ISSUE_W-1:0] done;
  logic [ISSUE_W-1:0] pending;
  logic [ISSUE_W-1:0] iv_raw;

  // Walk slots oldest-first; once a pending slot fails, no younger slot may issue.
  always_comb begin : issue_logic
    logic ok, haz, u1, u2;
    logic [REG_AW-1:0] r1, r2, d, dk;
    pending = bundle_valid & ~done;
    iv_raw  = '0;
    ok  = 1'b1;
    haz = 1'b0;
    u1  = 1'b0;
    u2  = 1'b0;
    r1  = '0;
    r2  = '0;
    d   = '0;
    dk  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      u1  = src1[i*SW+REG_AW];
      r1  = src1[i*SW +: REG_AW];
      u2  = src2[i*SW+REG_AW];
      r2  = src2[i*SW +: REG_AW];
      d   = dest[i*REG_AW +: REG_AW];
      haz = (u1 && cnt[r1] != 3'd0) || (u2 && cnt[r2] != 3'd0) ||
            (dest_we[i] && cnt[d] != 3'd0);
      for (int k = 0; k < i; k++) begin
        dk = dest[k*REG_AW +: REG_AW];
        if (iv_raw[k] && dest_we[k] &&
            ((u1 && dk == r1) || (u2 && dk == r2) || (dest_we[i] && dk == d)))
          haz = 1'b1;
      end
      iv_raw[i] = pending[i] & ~haz & ok;
      if (pending[i] && !iv_raw[i]) ok = 1'b0;
    end
  end

  assign issue_valid = flush ? '0 : iv_raw;
  assign enable      = flush | ~|(pending & ~iv_raw);

  // Countdowns tick every cycle, even under flush: their loads are already in flight.
  always_comb begin
    for (int r = 0; r < NREGS; r++)
      cnt_nxt[r] = (cnt[r] != 3'd0) ? cnt[r] - 3'd1 : 3'd0;
    for (int i = 0; i < ISSUE_W; i++)
      if (issue_valid[i] && is_load[i] && dest_we[i])
        cnt_nxt[dest[i*REG_AW +: REG_AW]] = LAT;
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++)
      busy_map[r] = (cnt[r] != 3'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done        <= '0;
      stall_count <= 16'd0;
      for (int r = 0; r < NREGS; r++) cnt[r] <= 3'd0;
    end else begin
      done <= enable ? '0 : (done | issue_valid);
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      if (|pending && !enable && !flush && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard_staller.sv
// Bench for issue_scoreboard_staller: directed scenarios with hand-derived
// expectations, then random bundles against a ready-time reference model.
module tb_issue_scoreboard_staller;
  localparam int IW = 2;
  localparam int AW = 3;
  localparam int LL = 2;
  localparam int NR = 8;
  localparam int SW = AW + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [IW-1:0] bundle_valid;
  logic [IW*SW-1:0] src1;
  logic [IW*SW-1:0] src2;
  logic [IW*AW-1:0] dest;
  logic [IW-1:0] dest_we;
  logic [IW-1:0] is_load;
  logic [IW-1:0] issue_valid;
  logic          enable;
  logic [NR-1:0] busy_map;
  logic [15:0]   stall_count;

  int total = 0;
  int bad = 0;

  // Reference model: a register is readable once the cycle number reaches ready_at.
  int      ready_at [NR];
  bit [IW-1:0] mdone;
  int      mstall;
  int      cyc;

  issue_scoreboard_staller #(.ISSUE_W(IW), .REG_AW(AW), .LOAD_LAT(LL)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bundle_valid(bundle_valid),
    .src1(src1), .src2(src2), .dest(dest), .dest_we(dest_we), .is_load(is_load),
    .issue_valid(issue_valid), .enable(enable), .busy_map(busy_map),
    .stall_count(stall_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clear_inputs();
    flush = 1'b0; bundle_valid = '0; src1 = '0; src2 = '0;
    dest = '0; dest_we = '0; is_load = '0;
  endtask

  task automatic set_slot(input int i, input bit v, input bit u1, input int r1,
                          input bit u2, input int r2, input bit we, input int d,
                          input bit ld);
    bundle_valid[i]    = v;
    src1[i*SW +: SW]   = {u1, 3'(r1)};
    src2[i*SW +: SW]   = {u2, 3'(r2)};
    dest[i*AW +: AW]   = 3'(d);
    dest_we[i]         = we;
    is_load[i]         = ld;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    mdone = '0;
    mstall = 0;
  endtask

  function automatic void model_eval(output logic [IW-1:0] eiv, output logic een,
                                     output logic [NR-1:0] ebusy, output bit anyp);
    bit [NR-1:0] written;
    bit ok, haz, u1, u2, we;
    logic [2:0] r1, r2, d;
    written = '0; ok = 1'b1; eiv = '0; een = 1'b1; anyp = 1'b0;
    for (int r = 0; r < NR; r++) ebusy[r] = (cyc < ready_at[r]);
    for (int i = 0; i < IW; i++) begin
      if (!bundle_valid[i] || mdone[i]) continue;
      anyp = 1'b1;
      u1 = src1[i*SW+AW]; r1 = src1[i*SW +: AW];
      u2 = src2[i*SW+AW]; r2 = src2[i*SW +: AW];
      we = dest_we[i];    d  = dest[i*AW +: AW];
      haz = (u1 && (ebusy[r1] || written[r1])) || (u2 && (ebusy[r2] || written[r2])) ||
            (we && (ebusy[d] || written[d]));
      if (ok && !haz) begin
        eiv[i] = 1'b1;
        if (we) written[d] = 1'b1;
      end else begin
        ok = 1'b0;
        een = 1'b0;
      end
    end
    if (flush) begin
      eiv = '0;
      een = 1'b1;
    end
  endfunction

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    set_slot(0, 1, 1, 2, 1, 3, 1, 1, 0);
    set_slot(1, 1, 1, 4, 0, 0, 1, 5, 0);
    #1;
    total++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL reset_iv: got %b want 11", issue_valid); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL reset_en: got %b want 1", enable); end
    total++; if (busy_map !== 8'h00) begin bad++; $display("FAIL reset_busy: got %h want 00", busy_map); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_independent();
    do_reset();
    set_slot(0, 1, 1, 3, 1, 4, 1, 1, 0);
    set_slot(1, 1, 1, 5, 1, 6, 1, 2, 0);
    #1;
    total++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL indep_iv: got %b want 11", issue_valid); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL indep_en: got %b want 1", enable); end
    tick(); clear_inputs(); #1;
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL indep_stall: got %0d want 0", stall_count); end
  endtask

  task automatic test_raw_split();
    do_reset();
    set_slot(0, 1, 1, 1, 1, 2, 1, 3, 0);
    set_slot(1, 1, 1, 3, 0, 0, 1, 5, 0);
    #1;
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL raw_c0_iv: got %b want 01", issue_valid); end
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL raw_c0_en: got %b want 0", enable); end
    tick(); #1;
    total++; if (issue_valid !== 2'b10) begin bad++; $display("FAIL raw_c1_iv: got %b want 10", issue_valid); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL raw_c1_en: got %b want 1", enable); end
    tick(); clear_inputs(); #1;
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL raw_stall: got %0d want 1", stall_count); end
  endtask

  task automatic test_load_use(input bit with_flush);
    do_reset();
    set_slot(0, 1, 1, 1, 0, 0, 1, 4, 1);
    #1;
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL lu_c0_iv: got %b want 01", issue_valid); end
    tick();
    clear_inputs();
    set_slot(0, 1, 1, 4, 0, 0, 1, 6, 0);
    set_slot(1, 1, 1, 2, 0, 0, 1, 7, 0);
    flush = with_flush;
    for (int c = 1; c <= 2; c++) begin
      #1;
      total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL lu_c%0d_iv: got %b want 00", c, issue_valid); end
      total++; if (busy_map[4] !== 1'b1) begin bad++; $display("FAIL lu_c%0d_busy4: got %b want 1", c, busy_map[4]); end
      if (c == 1 && with_flush) begin
        total++; if (enable !== 1'b1) begin bad++; $display("FAIL flush_en: got %b want 1", enable); end
      end
      tick();
      flush = 1'b0;
    end
    #1;
    total++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL lu_c3_iv: got %b want 11", issue_valid); end
    total++; if (busy_map[4] !== 1'b0) begin bad++; $display("FAIL lu_c3_busy4: got %b want 0", busy_map[4]); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL lu_c3_en: got %b want 1", enable); end
    tick(); clear_inputs(); #1;
    total++;
    if (stall_count !== (with_flush ? 16'd1 : 16'd2)) begin
      bad++; $display("FAIL lu_stall: got %0d want %0d", stall_count, with_flush ? 1 : 2);
    end
  endtask

  task automatic test_load_split();
    do_reset();
    set_slot(0, 1, 1, 1, 0, 0, 1, 5, 1);
    set_slot(1, 1, 1, 5, 0, 0, 1, 6, 0);
    #1;
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL ls_c0_iv: got %b want 01", issue_valid); end
    tick();
    for (int c = 1; c <= 2; c++) begin
      #1;
      total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL ls_c%0d_iv: got %b want 00", c, issue_valid); end
      total++; if (enable !== 1'b0) begin bad++; $display("FAIL ls_c%0d_en: got %b want 0", c, enable); end
      tick();
    end
    #1;
    total++; if (issue_valid !== 2'b10) begin bad++; $display("FAIL ls_c3_iv: got %b want 10", issue_valid); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL ls_c3_en: got %b want 1", enable); end
    tick(); clear_inputs(); #1;
    total++; if (stall_count !== 16'd3) begin bad++; $display("FAIL ls_stall: got %0d want 3", stall_count); end
  endtask

  task automatic test_reset_mid_split();
    do_reset();
    set_slot(0, 1, 1, 1, 1, 2, 1, 3, 0);
    set_slot(1, 1, 1, 3, 0, 0, 1, 5, 0);
    tick(); #1;
    total++; if (issue_valid !== 2'b10) begin bad++; $display("FAIL rm_pre_iv: got %b want 10", issue_valid); end
    reset = 1'b0;
    #1;
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL rm_rst_iv: got %b want 01", issue_valid); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rm_rst_stall: got %0d want 0", stall_count); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL rm_c0_iv: got %b want 01", issue_valid); end
    tick(); #1;
    total++; if (issue_valid !== 2'b10) begin bad++; $display("FAIL rm_c1_iv: got %b want 10", issue_valid); end
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL rm_c1_en: got %b want 1", enable); end
    tick(); clear_inputs();
  endtask

  task automatic test_random();
    logic [IW-1:0] eiv;
    logic          een;
    logic [NR-1:0] ebusy;
    bit            anyp;
    bit            hold;
    do_reset();
    model_reset();
    cyc = 0;
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        for (int i = 0; i < IW; i++)
          set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 4), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 4), $urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 15) == 0);
      if (n == 300) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
      end
      #1;
      model_eval(eiv, een, ebusy, anyp);
      total++; if (issue_valid !== eiv) begin bad++; $display("FAIL rnd_iv n=%0d: got %b want %b", n, issue_valid, eiv); end
      total++; if (enable !== een) begin bad++; $display("FAIL rnd_en n=%0d: got %b want %b", n, enable, een); end
      total++; if (busy_map !== ebusy) begin bad++; $display("FAIL rnd_busy n=%0d: got %h want %h", n, busy_map, ebusy); end
      total++; if (stall_count !== 16'(mstall)) begin bad++; $display("FAIL rnd_stall n=%0d: got %0d want %0d", n, stall_count, mstall); end
      for (int i = 0; i < IW; i++)
        if (eiv[i] && is_load[i] && dest_we[i]) ready_at[dest[i*AW +: AW]] = cyc + LL + 1;
      if (anyp && !een && !flush && mstall < 65535) mstall++;
      mdone = een ? '0 : (mdone | eiv);
      hold = !een;
      cyc++;
      tick();
    end
    clear_inputs();
  endtask

  // sequence and final report
  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_independent();
    test_raw_split();
    test_load_use(1'b0);
    test_load_split();
    test_load_use(1'b1);
    test_reset_mid_split();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
